// File: rtl/serial_link_pkg.sv
// Shared types for the serial link control blocks.
package serial_link_pkg;

    typedef enum logic [2:0] {
        CalibIdle  = 3'd0,
        CalibClear = 3'd1,
        CalibFill  = 3'd2,
        CalibCheck = 3'd3,
        CalibExit  = 3'd4
    } calib_state_e;

endpackage

// File: rtl/serial_link_calib_ctrl.sv
// Link calibration sequencer: drives the data-link raw-mode interface, broadcasts a rotating
// pattern on all channels, then checks the remote pattern channel by channel.
//
// state | meaning
// Idle  | link in normal mode, waiting for start
// Clear | raw mode on, flush TX raw FIFO and RX flow-control FIFO
// Fill  | push NumPatterns pattern words, broadcast on all channels
// Check | read back remote words per channel, with idle timeout
// Exit  | flush FIFOs, leave raw mode, pulse done unless aborted
module serial_link_calib_ctrl
    import serial_link_pkg::*;
#(
    parameter int unsigned          NumChannels     = 4,
    parameter int unsigned          DataWidth       = 16,
    parameter int unsigned          NumPatterns     = 8,
    parameter logic [DataWidth-1:0] PatternSeed     = 16'hA5C3,
    parameter int unsigned          TimeoutCycles   = 256,
    localparam int unsigned         Log2NumChannels = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       pass_o,
    output logic [NumChannels-1:0]     ch_ok_o,
    output logic                       cfg_raw_mode_en_o,
    output logic                       cfg_raw_mode_out_en_o,
    output logic [NumChannels-1:0]     cfg_raw_mode_out_ch_mask_o,
    output logic [DataWidth-1:0]       cfg_raw_mode_out_data_o,
    output logic                       cfg_raw_mode_out_data_valid_o,
    input  logic                       cfg_raw_mode_out_data_fifo_is_full_i,
    output logic                       cfg_raw_mode_out_data_fifo_clear_o,
    output logic                       cfg_flow_control_fifo_clear_o,
    output logic [Log2NumChannels-1:0] cfg_raw_mode_in_ch_sel_o,
    input  logic [DataWidth-1:0]       cfg_raw_mode_in_data_i,
    input  logic [NumChannels-1:0]     cfg_raw_mode_in_data_valid_i,
    output logic                       cfg_raw_mode_in_data_ready_o
);

    localparam int unsigned TxW  = $clog2(NumPatterns + 1);
    localparam int unsigned ChW  = $clog2(NumChannels + 1);
    localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);

    calib_state_e               state_q, state_d;
    logic [TxW-1:0]             tx_cnt_q, tx_cnt_d;
    logic [TxW-1:0]             rx_cnt_q, rx_cnt_d;
    logic [ChW-1:0]             ch_cnt_q, ch_cnt_d;
    logic [TmoW-1:0]            tmo_q, tmo_d;
    logic                       fail_q, fail_d;
    logic                       aborted_q, aborted_d;
    logic [NumChannels-1:0]     ch_ok_q, ch_ok_d;
    logic [Log2NumChannels-1:0] ch_sel;
    logic                       accept;
    logic                       mismatch;
    logic                       ch_done;

    // Seed rotated left by (k mod DataWidth); TX and RX share it.
    function automatic logic [DataWidth-1:0] pattern(input int unsigned k);
        logic [2*DataWidth-1:0] dbl;
        dbl = {PatternSeed, PatternSeed} << (k % DataWidth);
        return dbl[2*DataWidth-1:DataWidth];
    endfunction

    assign ch_sel   = ch_cnt_q[Log2NumChannels-1:0];
    assign accept   = cfg_raw_mode_in_data_valid_i[ch_sel];
    assign mismatch = (cfg_raw_mode_in_data_i != pattern(32'(rx_cnt_q)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= CalibIdle;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            ch_cnt_q  <= '0;
            tmo_q     <= '0;
            fail_q    <= 1'b0;
            aborted_q <= 1'b0;
            ch_ok_q   <= '0;
        end else begin
            state_q   <= state_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            ch_cnt_q  <= ch_cnt_d;
            tmo_q     <= tmo_d;
            fail_q    <= fail_d;
            aborted_q <= aborted_d;
            ch_ok_q   <= ch_ok_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_cnt_d  = tx_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        ch_cnt_d  = ch_cnt_q;
        tmo_d     = tmo_q;
        fail_d    = fail_q;
        aborted_d = aborted_q;
        ch_ok_d   = ch_ok_q;
        ch_done   = 1'b0;

        done_o                             = 1'b0;
        cfg_raw_mode_en_o                  = 1'b0;
        cfg_raw_mode_out_en_o              = 1'b0;
        cfg_raw_mode_out_ch_mask_o         = '0;
        cfg_raw_mode_out_data_o            = '0;
        cfg_raw_mode_out_data_valid_o      = 1'b0;
        cfg_raw_mode_out_data_fifo_clear_o = 1'b0;
        cfg_flow_control_fifo_clear_o      = 1'b0;
        cfg_raw_mode_in_ch_sel_o           = '0;
        cfg_raw_mode_in_data_ready_o       = 1'b0;

        unique case (state_q)
            CalibIdle: begin
                if (start_i) begin
                    state_d   = CalibClear;
                    tx_cnt_d  = '0;
                    rx_cnt_d  = '0;
                    ch_cnt_d  = '0;
                    tmo_d     = '0;
                    fail_d    = 1'b0;
                    aborted_d = 1'b0;
                    ch_ok_d   = '0;
                end
            end

            CalibClear: begin
                cfg_raw_mode_en_o                  = 1'b1;
                cfg_raw_mode_out_data_fifo_clear_o = 1'b1;
                cfg_flow_control_fifo_clear_o      = 1'b1;
                state_d                            = CalibFill;
            end

            CalibFill: begin
                cfg_raw_mode_en_o             = 1'b1;
                cfg_raw_mode_out_en_o         = 1'b1;
                cfg_raw_mode_out_ch_mask_o    = '1;
                cfg_raw_mode_out_data_o       = pattern(32'(tx_cnt_q));
                // Withholding valid on abort keeps a half-finished run from leaving a word behind.
                cfg_raw_mode_out_data_valid_o = !cfg_raw_mode_out_data_fifo_is_full_i && !abort_i;
                if (cfg_raw_mode_out_data_valid_o) begin
                    tx_cnt_d = tx_cnt_q + TxW'(1);
                    if (tx_cnt_q == TxW'(NumPatterns - 1)) begin
                        state_d = CalibCheck;
                    end
                end
            end

            CalibCheck: begin
                cfg_raw_mode_en_o            = 1'b1;
                cfg_raw_mode_out_en_o        = 1'b1;
                cfg_raw_mode_out_ch_mask_o   = '1;
                cfg_raw_mode_out_data_o      = pattern(32'(tx_cnt_q));
                cfg_raw_mode_in_ch_sel_o     = ch_sel;
                cfg_raw_mode_in_data_ready_o = 1'b1;
                if (accept) begin
                    rx_cnt_d = rx_cnt_q + TxW'(1);
                    tmo_d    = '0;
                    fail_d   = fail_q | mismatch;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
                if (accept && (rx_cnt_q == TxW'(NumPatterns - 1))) begin
                    ch_done         = 1'b1;
                    ch_ok_d[ch_sel] = !(fail_q | mismatch);
                end else if (!accept && (tmo_q == TmoW'(TimeoutCycles - 1))) begin
                    ch_done         = 1'b1;
                    ch_ok_d[ch_sel] = 1'b0;
                end
                if (ch_done) begin
                    rx_cnt_d = '0;
                    tmo_d    = '0;
                    fail_d   = 1'b0;
                    ch_cnt_d = ch_cnt_q + ChW'(1);
                    if (ch_cnt_q == ChW'(NumChannels - 1)) begin
                        state_d = CalibExit;
                    end
                end
            end

            CalibExit: begin
                cfg_raw_mode_out_data_fifo_clear_o = 1'b1;
                cfg_flow_control_fifo_clear_o      = 1'b1;
                done_o                             = !aborted_q;
                state_d                            = CalibIdle;
            end

            default: state_d = CalibIdle;
        endcase

        // An abort during Exit itself still returns to Idle, but the run no longer counts.
        if (abort_i && (state_q != CalibIdle)) begin
            aborted_d = 1'b1;
            ch_ok_d   = '0;
            done_o    = 1'b0;
            if (state_q != CalibExit) begin
                state_d = CalibExit;
            end
        end
    end

    assign busy_o  = (state_q != CalibIdle);
    assign ch_ok_o = ch_ok_q;
    assign pass_o  = &ch_ok_q;

endmodule
